timer_run_ctrl: RTL and testbench

// - Mode/run controller for the seconds counter chain (lsec 0..9, hsec 0..5). Turns it into a settable MM-less

---
 rtl/timer_run_ctrl_pkg.sv | 34 +++
 rtl/timer_run_ctrl_if.sv | 34 +++
 rtl/timer_run_ctrl_btn_edge.sv | 24 ++
 rtl/timer_run_ctrl.sv | 168 ++++++++++++++++
 tb/tb_timer_run_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_run_ctrl_pkg.sv
// Shared types for the countdown-timer run controller: FSM states, digit widths, edit-select codes.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package timer_run_ctrl_pkg;

    localparam int LSEC_W = 4;
    localparam int HSEC_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        SET_LSEC,
        SET_HSEC,
        LOAD,
        RUN,
        PAUSE,
        DONE
    } timer_state_t;

    // Display blink selector: which preset digit the user is editing.
    typedef enum logic [1:0] {
        EDIT_NONE = 2'b00,
        EDIT_LSEC = 2'b01,
        EDIT_HSEC = 2'b10
    } edit_sel_t;

    function automatic edit_sel_t edit_code(input timer_state_t s);
        case (s)
            SET_LSEC: return EDIT_LSEC;
            SET_HSEC: return EDIT_HSEC;
            default:  return EDIT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/timer_run_ctrl_if.sv
// Bundle between front panel / counter chain and the timer run controller.
// Latency: n/a (wires only).
// Backpressure: none; buttons are levels, second_imp is a free-running pulse.
// master: drives buttons, divider pulse and current counter values.
// slave : the controller, drives load strobe/presets, enable, direction, edit select and alarm.
interface timer_run_ctrl_if;
    import timer_run_ctrl_pkg::*;

    logic              btn_mode;
    logic              btn_inc;
    logic              btn_start;
    logic              second_imp;
    logic [LSEC_W-1:0] lsec_val;
    logic [HSEC_W-1:0] hsec_val;

    logic              set;
    logic [LSEC_W-1:0] lsec_init;
    logic [HSEC_W-1:0] hsec_init;
    logic              cnt_enable;
    logic              up_down;
    logic [1:0]        edit_sel;
    logic              done;

    modport master (
        output btn_mode, btn_inc, btn_start, second_imp, lsec_val, hsec_val,
        input  set, lsec_init, hsec_init, cnt_enable, up_down, edit_sel, done
    );

    modport slave (
        input  btn_mode, btn_inc, btn_start, second_imp, lsec_val, hsec_val,
        output set, lsec_init, hsec_init, cnt_enable, up_down, edit_sel, done
    );

endinterface

// File: rtl/timer_run_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level.
// Latency: rise is combinational from level, one cycle wide (previous level held in one register).
// Backpressure: none; holding the level high yields a single pulse.
// Ports: clk, rst_n (async active-low), level (debounced button), rise (1-cycle edge pulse).
module timer_run_ctrl_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/timer_run_ctrl.sv
// Mode/run controller turning the seconds counter chain into a settable 00..59 countdown timer.
// Latency: button edge acts on the next clock; all outputs registered except cnt_enable (state AND second_imp).
// Backpressure: none; coincident button edges resolve start > mode > inc, losers are dropped.
// Ports: clk, rst_n (async active-low), bus (slave side: buttons, divider pulse, counter values in;
//        load strobe, presets, count enable, direction, edit select, alarm out).
module timer_run_ctrl
    import timer_run_ctrl_pkg::*;
#(
    parameter int p_lsec_max  = 9,
    parameter int p_hsec_max  = 5,
    parameter int p_alarm_sec = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_run_ctrl_if.slave bus
);

    localparam int ALARM_W = $clog2(p_alarm_sec + 1);

    timer_state_t      state, state_nxt;
    logic [LSEC_W-1:0] preset_l;
    logic [HSEC_W-1:0] preset_h;
    logic [ALARM_W-1:0] alarm_cnt;

    logic              set_q;
    logic [LSEC_W-1:0] lsec_init_q;
    logic [HSEC_W-1:0] hsec_init_q;
    edit_sel_t         edit_sel_q;
    logic              done_q;

    logic mode_rise, inc_rise, start_rise;
    logic start_act, mode_act, inc_act;
    logic preset_nz, terminal, alarm_last;

    timer_run_ctrl_btn_edge u_edge_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.btn_mode),
        .rise  (mode_rise)
    );

    timer_run_ctrl_btn_edge u_edge_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.btn_inc),
        .rise  (inc_rise)
    );

    timer_run_ctrl_btn_edge u_edge_start (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.btn_start),
        .rise  (start_rise)
    );

    // Only the highest-priority edge of the cycle is allowed to act.
    assign start_act = start_rise;
    assign mode_act  = mode_rise & ~start_rise;
    assign inc_act   = inc_rise & ~start_rise & ~mode_rise;

    assign preset_nz  = (preset_l != '0) || (preset_h != '0);
    // Last decrement: the counter shows 01 and this pulse takes it to 00.
    assign terminal   = bus.second_imp && (bus.hsec_val == '0) && (bus.lsec_val == LSEC_W'(1));
    assign alarm_last = bus.second_imp && (alarm_cnt == ALARM_W'(p_alarm_sec - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_act) begin
                    if (preset_nz) state_nxt = LOAD;
                end else if (mode_act) begin
                    state_nxt = SET_LSEC;
                end
            end
            SET_LSEC: begin
                if (start_act) begin
                    if (preset_nz) state_nxt = LOAD;
                end else if (mode_act) begin
                    state_nxt = SET_HSEC;
                end
            end
            SET_HSEC: begin
                if (start_act) begin
                    if (preset_nz) state_nxt = LOAD;
                end else if (mode_act) begin
                    state_nxt = IDLE;
                end
            end
            LOAD:  state_nxt = RUN;
            RUN: begin
                // Reaching zero outranks any button in the same cycle.
                if (terminal)       state_nxt = DONE;
                else if (start_act) state_nxt = PAUSE;
                else if (mode_act)  state_nxt = IDLE;
            end
            PAUSE: begin
                if (start_act)     state_nxt = RUN;
                else if (mode_act) state_nxt = IDLE;
            end
            DONE: begin
                if (start_rise || mode_rise || inc_rise) state_nxt = IDLE;
                else if (alarm_last)                     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Presets survive a run so the same time can be restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset_l <= '0;
            preset_h <= '0;
        end else if (inc_act) begin
            if (state == SET_LSEC) begin
                preset_l <= (preset_l == LSEC_W'(p_lsec_max)) ? '0 : preset_l + LSEC_W'(1);
            end
            if (state == SET_HSEC) begin
                preset_h <= (preset_h == HSEC_W'(p_hsec_max)) ? '0 : preset_h + HSEC_W'(1);
            end
        end
    end

    // Held at zero outside DONE, so it starts from zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt <= '0;
        end else if (state != DONE) begin
            alarm_cnt <= '0;
        end else if (bus.second_imp) begin
            alarm_cnt <= alarm_cnt + ALARM_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q       <= 1'b0;
            lsec_init_q <= '0;
            hsec_init_q <= '0;
            edit_sel_q  <= EDIT_NONE;
            done_q      <= 1'b0;
        end else begin
            set_q       <= (state_nxt == LOAD);
            lsec_init_q <= (state_nxt == LOAD) ? preset_l : '0;
            hsec_init_q <= (state_nxt == LOAD) ? preset_h : '0;
            edit_sel_q  <= edit_code(state_nxt);
            done_q      <= (state_nxt == DONE);
        end
    end

    assign bus.set        = set_q;
    assign bus.lsec_init  = lsec_init_q;
    assign bus.hsec_init  = hsec_init_q;
    assign bus.edit_sel   = edit_sel_q;
    assign bus.done       = done_q;
    assign bus.cnt_enable = bus.second_imp & (state == RUN);
    assign bus.up_down    = 1'b0;

endmodule

// File: tb/tb_timer_run_ctrl.sv
module tb_timer_run_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_run_ctrl_if bus ();

    timer_run_ctrl #(
        .p_lsec_max  (9),
        .p_hsec_max  (5),
        .p_alarm_sec (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Counter chain stand-in (down counter 59..00, parallel load on set)
    int cnt_l, cnt_h;
    bit set_seen;
    int en_seen;
    int last_l, last_h;

    // Reference model state, kept as plain names and numbers
    string ms;
    int    pl, ph, alarm;
    bit    pm, pi, ps;

    typedef struct {
        bit m, i, s, p;
        int e_set, e_l, e_h, e_sel, e_done, e_en;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int e_set, input int e_l, input int e_h,
                           input int e_sel, input int e_done, input int e_en);
        chk({tag, ".set"},        int'(bus.set),        e_set);
        chk({tag, ".lsec_init"},  int'(bus.lsec_init),  e_l);
        chk({tag, ".hsec_init"},  int'(bus.hsec_init),  e_h);
        chk({tag, ".edit_sel"},   int'(bus.edit_sel),   e_sel);
        chk({tag, ".done"},       int'(bus.done),       e_done);
        chk({tag, ".cnt_enable"}, int'(bus.cnt_enable), e_en);
    endtask

    // Called at a falling edge: drive this cycle's inputs, then sample outputs 1 time unit later.
    task automatic apply(input logic m, input logic i, input logic s, input logic p);
        bus.btn_mode   = m;
        bus.btn_inc    = i;
        bus.btn_start  = s;
        bus.second_imp = p;
        bus.lsec_val   = 4'(cnt_l);
        bus.hsec_val   = 3'(cnt_h);
        #1;
        if (bus.set) begin
            set_seen = 1'b1;
            last_l   = int'(bus.lsec_init);
            last_h   = int'(bus.hsec_init);
        end
        if (bus.cnt_enable) en_seen++;
    endtask

    // Counter chain reacts to what the DUT drove this cycle, then wait for the next falling edge.
    task automatic advance();
        if (bus.set) begin
            cnt_l = int'(bus.lsec_init);
            cnt_h = int'(bus.hsec_init);
        end else if (bus.cnt_enable) begin
            if (cnt_l == 0) begin
                cnt_l = 9;
                cnt_h = (cnt_h == 0) ? 5 : cnt_h - 1;
            end else begin
                cnt_l = cnt_l - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic m, input logic i, input logic s, input logic p);
        apply(m, i, s, p);
        advance();
    endtask

    // b: 0 mode, 1 inc, 2 start
    task automatic press(input int b);
        step(b == 0, b == 1, b == 2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.btn_start  = 1'b0;
        bus.second_imp = 1'b0;
        bus.lsec_val   = '0;
        bus.hsec_val   = '0;
        cnt_l = 0;
        cnt_h = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input int m, input int i, input int s, input int p, input int e_set,
                       input int e_l, input int e_h, input int e_sel, input int e_done, input int e_en);
        vec_t v;
        v.m = (m != 0); v.i = (i != 0); v.s = (s != 0); v.p = (p != 0);
        v.e_set = e_set; v.e_l = e_l; v.e_h = e_h; v.e_sel = e_sel; v.e_done = e_done; v.e_en = e_en;
        tab.push_back(v);
    endtask

    task automatic model_reset();
        ms = "idle"; pl = 0; ph = 0; alarm = 0;
        pm = 1'b0; pi = 1'b0; ps = 1'b0;
    endtask

    // One clock of the timer rules, fed with the levels and counter value seen this cycle.
    task automatic model_step(input logic m, input logic i, input logic s, input logic p, input int secs);
        bit em, ei, es, ws, wm, wi, nz;
        em = m & ~pm; ei = i & ~pi; es = s & ~ps;
        pm = m; pi = i; ps = s;
        ws = es;
        wm = em & ~es;
        wi = ei & ~es & ~em;
        nz = (pl != 0) || (ph != 0);
        if (ms == "idle") begin
            if (ws && nz) ms = "load";
            else if (wm)  ms = "set_l";
        end else if (ms == "set_l") begin
            if (ws && nz)   ms = "load";
            else if (wm)    ms = "set_h";
            else if (wi)    pl = (pl + 1) % 10;
        end else if (ms == "set_h") begin
            if (ws && nz)   ms = "load";
            else if (wm)    ms = "idle";
            else if (wi)    ph = (ph + 1) % 6;
        end else if (ms == "load") begin
            ms = "run";
        end else if (ms == "run") begin
            if (p && secs == 1) begin
                ms = "done";
                alarm = 0;
            end else if (ws) ms = "pause";
            else if (wm)     ms = "idle";
        end else if (ms == "pause") begin
            if (ws)      ms = "run";
            else if (wm) ms = "idle";
        end else if (ms == "done") begin
            if (em || ei || es) ms = "idle";
            else if (p) begin
                alarm++;
                if (alarm == 3) ms = "idle";
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic rm, ri, rs, rp;
    int odds, secs;

    initial begin
        set_seen = 1'b0; en_seen = 0; last_l = 0; last_h = 0;

        // ---------------- reset state ----------------
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.up_down", int'(bus.up_down), 0);
        advance();

        // ---------------- table: mode, inc x3, mode, inc x2, start ----------------
        //   m  i  s  p   set l  h  sel done en
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 2, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 2, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 2, 0, 0);
        add(0, 0, 1, 0,   0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0,   1, 3, 2, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        do_reset();
        for (int k = 0; k < tab.size(); k++) begin
            apply(tab[k].m, tab[k].i, tab[k].s, tab[k].p);
            chk_out($sformatf("vec%0d", k), tab[k].e_set, tab[k].e_l, tab[k].e_h,
                    tab[k].e_sel, tab[k].e_done, tab[k].e_en);
            advance();
        end
        chk("vec.counter_l", cnt_l, 2);
        chk("vec.counter_h", cnt_h, 2);

        // ---------------- preset wrap; start with 00 ignored ----------------
        do_reset();
        set_seen = 1'b0;
        press(0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);    // held inc counts once
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) press(1);
        press(2);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_l.edit_sel", int'(bus.edit_sel), 1);
        chk("wrap_l.no_set", int'(set_seen), 0);
        advance();
        press(0);
        repeat (6) press(1);
        press(0);
        press(2);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_h.edit_sel", int'(bus.edit_sel), 0);
        chk("wrap_h.no_set", int'(set_seen), 0);
        advance();
        press(0);
        press(1);
        press(2);
        chk("wrap.load_seen", int'(set_seen), 1);
        chk("wrap.load_l", last_l, 1);
        chk("wrap.load_h", last_h, 0);

        // ---------------- preset 02 run to alarm ----------------
        do_reset();
        press(0);
        press(1);
        press(1);
        press(2);
        en_seen = 0;
        for (int c = 0; c < 60; c++) begin
            apply(1'b0, 1'b0, 1'b0, (c % 10) == 9);
            if (c == 19) chk("alarm.done_at_pulse2", int'(bus.done), 0);
            if (c == 20) chk("alarm.done_rise", int'(bus.done), 1);
            if (c == 49) chk("alarm.done_at_pulse5", int'(bus.done), 1);
            if (c == 50) chk("alarm.done_fall", int'(bus.done), 0);
            advance();
        end
        chk("alarm.enable_count", en_seen, 2);
        chk("alarm.counter", cnt_h * 10 + cnt_l, 0);
        press(0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk("alarm.back_idle", int'(bus.edit_sel), 1);
        advance();

        // ---------------- pause / resume ----------------
        do_reset();
        press(0);
        repeat (5) press(1);
        press(2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        press(2);
        en_seen = 0;
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("pause.no_enable", en_seen, 0);
        chk("pause.frozen", cnt_l, 4);
        set_seen = 1'b0;
        press(2);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resume.enable", int'(bus.cnt_enable), 1);
        advance();
        chk("resume.no_set", int'(set_seen), 0);
        chk("resume.counter", cnt_l, 3);

        // ---------------- coincident edges in IDLE, preset 05 ----------------
        do_reset();
        press(0);
        repeat (5) press(1);
        press(0);
        press(0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("coincide.load", 1, 5, 0, 0, 0, 0);
        advance();
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("coincide.run", 0, 0, 0, 0, 0, 0);
        advance();
        press(0);
        press(2);
        chk("coincide.preset_l", last_l, 5);
        chk("coincide.preset_h", last_h, 0);

        // ---------------- asynchronous reset mid-RUN ----------------
        do_reset();
        press(0);
        repeat (3) press(1);
        press(2);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("arst.pre_enable", int'(bus.cnt_enable), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst.during", 0, 0, 0, 0, 0, 0);
        chk("arst.up_down", int'(bus.up_down), 0);
        set_seen = 1'b0;
        bus.second_imp = 1'b0;
        cnt_l = 0;
        cnt_h = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("arst.after", 0, 0, 0, 0, 0, 0);
        advance();
        press(0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk("arst.idle_then_mode", int'(bus.edit_sel), 1);
        advance();
        press(2);
        chk("arst.preset_cleared", int'(set_seen), 0);

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        rm = 1'b0; ri = 1'b0; rs = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            odds = (((c / 400) % 2) == 0) ? 8 : 600;
            if ($urandom_range(0, odds - 1) == 0) rm = ~rm;
            if ($urandom_range(0, odds - 1) == 0) ri = ~ri;
            if ($urandom_range(0, odds - 1) == 0) rs = ~rs;
            rp = ($urandom_range(0, 2) == 0);
            apply(rm, ri, rs, rp);
            chk_out($sformatf("rnd%0d", c),
                    int'(ms == "load"),
                    (ms == "load") ? pl : 0,
                    (ms == "load") ? ph : 0,
                    (ms == "set_l") ? 1 : ((ms == "set_h") ? 2 : 0),
                    int'(ms == "done"),
                    int'(rp && (ms == "run")));
            secs = int'(bus.hsec_val) * 10 + int'(bus.lsec_val);
            model_step(rm, ri, rs, rp, secs);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
